multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory, and PC/IR/ALUOut/Data registers. It supports the same instruction set as the single-cycle main decoder: lw, sw, R-type, I-type ALU, beq, jal. It sits beside the existing ALU decoder, which consumes `ALUOp`, and drives every datapath enable and mux select. A `mem_ready` handshake lets memory stall any access state.

---
 rtl/multicycle_controller_pkg.sv | 48 ++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_imm_src_decoder.sv | 19 +
 rtl/multicycle_controller.sv | 139 +++++++++++++
 tb/tb_multicycle_controller.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The state encodings are visible on the debug port, so their values are fixed.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The master side is the controller: it reads op/zero/mem_ready and drives every enable and select.
interface multicycle_controller_if;

  logic [6:0] op;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, illegal, state
  );

endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Immediate format select, decoded purely from the opcode and independent of FSM state.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RISC-V datapath (lw, sw, R, I, beq, jal).
// Outputs decode from the state register; only mem_ready/zero qualify a few strobes.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  multicycle_controller_if.master   ctrl
);

  state_t state_q, state_d;

  logic pcUpdate;
  logic branch;
  logic irWrite;
  logic regWrite;
  logic memWrite;
  logic retireRaw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (ctrl.op == OP_SW)      state_d = S_MEMWRITE;
        else if (ctrl.op == OP_LW) state_d = S_MEMREAD;
        else                       state_d = S_TRAP;
      end
      S_MEMREAD:  if (ctrl.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ctrl.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    pcUpdate       = 1'b0;
    branch         = 1'b0;
    irWrite        = 1'b0;
    regWrite       = 1'b0;
    memWrite       = 1'b0;
    retireRaw      = 1'b0;
    ctrl.AdrSrc    = 1'b0;
    ctrl.ResultSrc = RES_ALUOUT;
    ctrl.ALUSrcA   = SRCA_PC;
    ctrl.ALUSrcB   = SRCB_RD2;
    ctrl.ALUOp     = ALUOP_ADD;
    ctrl.illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.ALUSrcB   = SRCB_FOUR;
        ctrl.ResultSrc = RES_ALURESULT;
        irWrite        = ctrl.mem_ready;
        pcUpdate       = ctrl.mem_ready;
      end
      // Decode speculatively forms OldPC + imm for a possible branch or jump.
      S_DECODE: begin
        ctrl.ALUSrcA = SRCA_OLDPC;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl.ALUSrcA = SRCA_RD1;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: ctrl.AdrSrc = 1'b1;
      S_MEMWB: begin
        ctrl.ResultSrc = RES_DATA;
        regWrite       = 1'b1;
        retireRaw      = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.AdrSrc = 1'b1;
        memWrite    = 1'b1;
        retireRaw   = ctrl.mem_ready;
      end
      S_EXECR: begin
        ctrl.ALUSrcA = SRCA_RD1;
        ctrl.ALUOp   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.ALUSrcA = SRCA_RD1;
        ctrl.ALUSrcB = SRCB_IMM;
        ctrl.ALUOp   = ALUOP_FUNCT;
      end
      S_JAL: begin
        ctrl.ALUSrcA = SRCA_OLDPC;
        ctrl.ALUSrcB = SRCB_FOUR;
        pcUpdate     = 1'b1;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        retireRaw = 1'b1;
      end
      S_BEQ: begin
        ctrl.ALUSrcA = SRCA_RD1;
        ctrl.ALUOp   = ALUOP_SUB;
        branch       = 1'b1;
        retireRaw    = 1'b1;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset suppresses every architectural write even when the state is mid-instruction.
  assign ctrl.PCWrite  = ~reset & ((branch & ctrl.zero) | pcUpdate);
  assign ctrl.IRWrite  = ~reset & irWrite;
  assign ctrl.RegWrite = ~reset & regWrite;
  assign ctrl.MemWrite = ~reset & memWrite;
  assign ctrl.retire   = ~reset & retireRaw;
  assign ctrl.state    = state_q;

  imm_src_decoder uImmSrc (
    .op     (ctrl.op),
    .ImmSrc (ctrl.ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller; expected outputs are hand-written per cycle.
// Bit order of expected output word: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc retire illegal.
module tb_multicycle_controller;

  localparam logic [6:0] lwOp  = 7'b0000011;
  localparam logic [6:0] swOp  = 7'b0100011;
  localparam logic [6:0] rOp   = 7'b0110011;
  localparam logic [6:0] iOp   = 7'b0010011;
  localparam logic [6:0] jalOp = 7'b1101111;
  localparam logic [6:0] beqOp = 7'b1100011;
  localparam logic [6:0] badOp = 7'b1111111;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_controller_if ctrlIf ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrlIf)
  );

  logic [16:0] outBits;
  assign outBits = {ctrlIf.PCWrite, ctrlIf.AdrSrc, ctrlIf.MemWrite, ctrlIf.IRWrite,
                    ctrlIf.RegWrite, ctrlIf.ResultSrc, ctrlIf.ALUSrcA, ctrlIf.ALUSrcB,
                    ctrlIf.ALUOp, ctrlIf.ImmSrc, ctrlIf.retire, ctrlIf.illegal};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  expState;
    logic [16:0] expBits;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mkVec(input logic rst, input logic [6:0] op, input logic zero,
                                 input logic rdy, input logic [3:0] st, input logic [16:0] bits);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = zero; v.rdy = rdy; v.expState = st; v.expBits = bits;
    return v;
  endfunction

  task automatic addVec(input logic rst, input logic [6:0] op, input logic zero,
                        input logic rdy, input logic [3:0] st, input logic [16:0] bits);
    vecs.push_back(mkVec(rst, op, zero, rdy, st, bits));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset            = v.rst;
    ctrlIf.op        = v.op;
    ctrlIf.zero      = v.zero;
    ctrlIf.mem_ready = v.rdy;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    #2;
    checks++;
    if (ctrlIf.state !== v.expState) begin
      failures++;
      $display("[TB] FAIL %s state: got %0d expected %0d", tag, ctrlIf.state, v.expState);
    end
    checks++;
    if (outBits !== v.expBits) begin
      failures++;
      $display("[TB] FAIL %s outputs: got %b expected %b", tag, outBits, v.expBits);
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  initial begin
    reset            = 1'b1;
    ctrlIf.op        = lwOp;
    ctrlIf.zero      = 1'b0;
    ctrlIf.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // lw, no stall: 0,1,2,3,4
    addVec(0, lwOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0);
    addVec(0, lwOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0);
    addVec(0, lwOp, 0, 1, 4'd2, 17'b0_0_0_0_0_00_10_01_00_00_0_0);
    addVec(0, lwOp, 0, 1, 4'd3, 17'b0_1_0_0_0_00_00_00_00_00_0_0);
    addVec(0, lwOp, 0, 1, 4'd4, 17'b0_0_0_0_1_01_00_00_00_00_1_0);
    // sw with two stall cycles in MemWrite
    addVec(0, swOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_01_0_0);
    addVec(0, swOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_01_0_0);
    addVec(0, swOp, 0, 1, 4'd2, 17'b0_0_0_0_0_00_10_01_00_01_0_0);
    addVec(0, swOp, 0, 0, 4'd5, 17'b0_1_1_0_0_00_00_00_00_01_0_0);
    addVec(0, swOp, 0, 0, 4'd5, 17'b0_1_1_0_0_00_00_00_00_01_0_0);
    addVec(0, swOp, 0, 1, 4'd5, 17'b0_1_1_0_0_00_00_00_00_01_1_0);
    // R-type with one Fetch stall
    addVec(0, rOp, 0, 0, 4'd0, 17'b0_0_0_0_0_10_00_10_00_00_0_0);
    addVec(0, rOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0);
    addVec(0, rOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0);
    addVec(0, rOp, 0, 1, 4'd6, 17'b0_0_0_0_0_00_10_00_10_00_0_0);
    addVec(0, rOp, 0, 1, 4'd7, 17'b0_0_0_0_1_00_00_00_00_00_1_0);
    // I-type
    addVec(0, iOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0);
    addVec(0, iOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0);
    addVec(0, iOp, 0, 1, 4'd8, 17'b0_0_0_0_0_00_10_01_10_00_0_0);
    addVec(0, iOp, 0, 1, 4'd7, 17'b0_0_0_0_1_00_00_00_00_00_1_0);
    // jal
    addVec(0, jalOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_11_0_0);
    addVec(0, jalOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_11_0_0);
    addVec(0, jalOp, 0, 1, 4'd9, 17'b1_0_0_0_0_00_01_10_00_11_0_0);
    addVec(0, jalOp, 0, 1, 4'd7, 17'b0_0_0_0_1_00_00_00_00_11_1_0);
    // beq taken
    addVec(0, beqOp, 1, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_10_0_0);
    addVec(0, beqOp, 1, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_10_0_0);
    addVec(0, beqOp, 1, 1, 4'd10, 17'b1_0_0_0_0_00_10_00_01_10_1_0);
    // beq not taken
    addVec(0, beqOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_10_0_0);
    addVec(0, beqOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_10_0_0);
    addVec(0, beqOp, 0, 1, 4'd10, 17'b0_0_0_0_0_00_10_00_01_10_1_0);
    // lw with one MemRead stall
    addVec(0, lwOp, 1, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0);
    addVec(0, lwOp, 1, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0);
    addVec(0, lwOp, 1, 1, 4'd2, 17'b0_0_0_0_0_00_10_01_00_00_0_0);
    addVec(0, lwOp, 1, 0, 4'd3, 17'b0_1_0_0_0_00_00_00_00_00_0_0);
    addVec(0, lwOp, 1, 1, 4'd3, 17'b0_1_0_0_0_00_00_00_00_00_0_0);
    addVec(0, lwOp, 1, 1, 4'd4, 17'b0_0_0_0_1_01_00_00_00_00_1_0);
    addVec(0, rOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset during MemRead of lw with mem_ready high: no MemWB, clean refetch.
    runVec("rstMid fetch",   mkVec(0, lwOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0));
    runVec("rstMid memadr",  mkVec(0, lwOp, 0, 1, 4'd2, 17'b0_0_0_0_0_00_10_01_00_00_0_0));
    runVec("rstMid memread", mkVec(1, lwOp, 0, 1, 4'd3, 17'b0_1_0_0_0_00_00_00_00_00_0_0));
    runVec("rstMid after",   mkVec(0, lwOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0));
    runVec("rstMid decode",  mkVec(0, lwOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0));
    runVec("rstMid memadr2", mkVec(0, lwOp, 0, 1, 4'd2, 17'b0_0_0_0_0_00_10_01_00_00_0_0));
    runVec("rstMid memrd2",  mkVec(0, lwOp, 0, 1, 4'd3, 17'b0_1_0_0_0_00_00_00_00_00_0_0));
    // Reset held while in MemWB must mask RegWrite and retire.
    runVec("rstWB memwb",    mkVec(1, lwOp, 0, 1, 4'd4, 17'b0_0_0_0_0_01_00_00_00_00_0_0));
    runVec("rstWB after",    mkVec(0, badOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_00_0_0));

    // Illegal opcode: Trap holds with no writes regardless of zero/mem_ready.
    runVec("trap decode", mkVec(0, badOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_00_0_0));
    for (int i = 0; i < 20; i++) begin
      runVec($sformatf("trap cyc%0d", i),
             mkVec(0, badOp, i[0], i[1], 4'd11, 17'b0_0_0_0_0_00_00_00_00_00_0_1));
    end
    runVec("trap reset", mkVec(1, badOp, 1, 1, 4'd11, 17'b0_0_0_0_0_00_00_00_00_00_0_1));
    runVec("trap exit",  mkVec(0, jalOp, 0, 1, 4'd0, 17'b1_0_0_1_0_10_00_10_00_11_0_0));
    runVec("trap next",  mkVec(0, jalOp, 0, 1, 4'd1, 17'b0_0_0_0_0_00_01_01_00_11_0_0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
